instr_fetch_ctrl: RTL and testbench
===================================

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter IW SHALL be: default 8; instruction address width in bits.
REQ-002 Parameter HALT_INST SHALL be: default 9'h1FF; instruction word that terminates the program.
REQ-003 Port Clk SHALL be: input, 1 bit; the single clock; all state updates on its rising edge.
REQ-004 Port Reset SHALL be: input, 1 bit; synchronous, active-high.
REQ-005 Port Start SHALL be: input, 1 bit; begins execution at address 0.
REQ-006 Port InstAddress SHALL be: output, IW bits; the PC, driven to the instruction ROM address input.
REQ-007 Port InstIn SHALL be: input, 9 bits; combinational ROM data for InstAddress.
REQ-008 Port Instr SHALL be: output, 9 bits; registered instruction presented to decode.
REQ-009 Port InstPC SHALL be: output, IW bits; the address Instr was fetched from.
REQ-010 Port InstValid SHALL be: output, 1 bit; Instr/InstPC hold a valid instruction.
REQ-011 Port InstReady SHALL be: input, 1 bit; decode accepts Instr this cycle.
REQ-012 Port BranchEn SHALL be: input, 1 bit; the instruction accepted this cycle is a taken branch.
REQ-013 Port BranchRel SHALL be: input, 1 bit; 1 = relative target, 0 = absolute target.
REQ-014 Port BranchTarget SHALL be: input, IW bits; absolute address, or two's-complement offset when BranchRel=1.
REQ-015 Port Done SHALL be: output, 1 bit; program has halted.
REQ-016 Port InstCount SHALL be: output, 16 bits; count of accepted instructions since the last Start.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-018 In IDLE, Start=1 SHALL set PC=0, InstValid=0, InstCount=0 and state=RUN on the next edge.
REQ-019 In RUN, a load SHALL occur when InstValid=0, or when InstValid=1 and InstReady=1 and BranchEn=0.
- Load: Instr<=InstIn, InstPC<=PC, InstValid<=1, PC<=PC+1.
REQ-020 PC increment SHALL wrap modulo 2**IW (e.g. 8'hFF -> 8'h00).
REQ-021 InstValid=1 with InstReady=0 SHALL hold Instr, InstPC and PC unchanged.
REQ-022 A branch SHALL occur when InstValid=1, InstReady=1 and BranchEn=1.
- Branch: PC<=BranchTarget when BranchRel=0, else PC<=InstPC+BranchTarget (mod 2**IW); InstValid<=0.
- Result: exactly one bubble cycle; the sequential ROM word is discarded.
REQ-023 BranchEn SHALL be ignored unless InstValid=1 and InstReady=1.
REQ-024 On a load where InstIn==HALT_INST, the block SHALL NOT present that word; instead InstValid<=0, state<=DONE.
- Exception: if an accepted branch occurs in the same cycle, the branch wins and the state stays RUN.
- A halt load concurrent with acceptance of the prior instruction SHALL still count that instruction.
REQ-025 Done SHALL be 1 exactly while state=DONE.
- In DONE, PC SHALL hold the halt address and InstValid SHALL be 0.
REQ-026 Start=1 in DONE SHALL behave as in IDLE (REQ-018); Start SHALL be ignored in RUN.
REQ-027 InstCount SHALL increment on each cycle with InstValid=1 and InstReady=1, saturating at 16'hFFFF.
REQ-028 Timing: with Start=1 at edge t, InstAddress SHALL be 0 after t and InstValid=1 with Instr=ROM[0] after t+1.
REQ-029 Sustained InstReady=1 with no branches SHALL yield one instruction per cycle.

Reset
REQ-030 Reset=1 at any edge, including mid-RUN, SHALL force the following on the next edge:
- state=IDLE, PC=0, Instr=0, InstPC=0, InstValid=0, Done=0, InstCount=0.
REQ-031 Reset SHALL take priority over Start, branch and halt.

Structure
REQ-032 Package fetch_pkg SHALL contain the FSM state enum (IDLE, RUN, DONE) and the default IW and HALT_INST constants.
REQ-033 The block SHALL be a single module with no sub-module; the instruction ROM is instantiated by the parent and connected via InstAddress/InstIn.

Verification
REQ-034 Scenario: ROM {0:9'h10C, 1:9'h13C, 2:9'h1FF}, InstReady=1, pulse Start -> Instr 9'h10C then 9'h13C on consecutive cycles; then Done=1, InstCount=2, InstAddress=2.
REQ-035 Scenario: InstReady low 3 cycles while Instr=9'h13C -> Instr, InstPC=1 and PC=2 held, InstCount unchanged; resumes when InstReady=1.
REQ-036 Scenario: branch accepted at InstPC=5 with BranchRel=1, BranchTarget=8'hFE -> one bubble, next InstPC=3; with BranchRel=0, BranchTarget=8'h20 -> next InstPC=8'h20.
REQ-037 Scenario: branch accepted while InstIn==HALT_INST -> no DONE; execution continues at the target.
REQ-038 Scenario: PC=8'hFF with no halt -> next InstPC=8'h00.
REQ-039 Scenario: Reset asserted mid-RUN with InstValid=1 -> all outputs reset values next cycle; Start afterwards restarts at address 0 with InstCount=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states,
// default geometry and a small saturating-counter helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  localparam int          DEF_IW        = 8;
  localparam logic [8:0]  DEF_HALT_INST = 9'h1FF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives the ROM address, presents one registered
// instruction at a time to decode, and handles branches, halt and restart.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int         IW        = DEF_IW,
  parameter logic [8:0] HALT_INST = DEF_HALT_INST
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic [IW-1:0] InstAddress,
  input  logic [8:0]    InstIn,
  output logic [8:0]    Instr,
  output logic [IW-1:0] InstPC,
  output logic          InstValid,
  input  logic          InstReady,
  input  logic          BranchEn,
  input  logic          BranchRel,
  input  logic [IW-1:0] BranchTarget,
  output logic          Done,
  output logic [15:0]   InstCount
);

  localparam logic [IW-1:0] PC_ONE  = IW'(1);
  localparam logic [IW-1:0] PC_ZERO = IW'(0);

  fetch_state_e  state_r, state_nxt;
  logic [IW-1:0] pc_r, pc_nxt;
  logic [8:0]    instr_r, instr_nxt;
  logic [IW-1:0] ipc_r, ipc_nxt;
  logic          valid_r, valid_nxt;
  logic [15:0]   count_r, count_nxt;
  logic          done_r;
  logic          accept_s;

  assign accept_s = valid_r & InstReady;

  // Next-state logic; a taken branch outranks the sequential load, which in turn
  // turns into a halt when the fetched word is the halt instruction.
  always_comb begin
    state_nxt = state_r;
    pc_nxt    = pc_r;
    instr_nxt = instr_r;
    ipc_nxt   = ipc_r;
    valid_nxt = valid_r;
    count_nxt = count_r;
    case (state_r)
      IDLE, DONE: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = PC_ZERO;
          valid_nxt = 1'b0;
          count_nxt = 16'd0;
        end else begin
          valid_nxt = 1'b0;
        end
      end
      RUN: begin
        if (accept_s) begin
          count_nxt = sat_inc16(count_r);
        end else begin
          count_nxt = count_r;
        end
        if (accept_s && BranchEn) begin
          pc_nxt    = BranchRel ? (ipc_r + BranchTarget) : BranchTarget;
          valid_nxt = 1'b0;
        end else if (!valid_r || accept_s) begin
          if (InstIn == HALT_INST) begin
            valid_nxt = 1'b0;
            state_nxt = DONE;
          end else begin
            instr_nxt = InstIn;
            ipc_nxt   = pc_r;
            valid_nxt = 1'b1;
            pc_nxt    = pc_r + PC_ONE;
          end
        end else begin
          pc_nxt = pc_r;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
      pc_r    <= PC_ZERO;
      instr_r <= 9'd0;
      ipc_r   <= PC_ZERO;
      valid_r <= 1'b0;
      count_r <= 16'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      pc_r    <= pc_nxt;
      instr_r <= instr_nxt;
      ipc_r   <= ipc_nxt;
      valid_r <= valid_nxt;
      count_r <= count_nxt;
      done_r  <= (state_nxt == DONE);
    end
  end

  assign InstAddress = pc_r;
  assign Instr       = instr_r;
  assign InstPC      = ipc_r;
  assign InstValid   = valid_r;
  assign InstCount   = count_r;
  assign Done        = done_r;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// against a cycle-level behavioural model of the fetch rules.
module tb_instr_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, ready, br_en, br_rel;
  logic [7:0] br_tgt;
  logic [7:0] inst_address, inst_pc;
  logic [8:0] inst_in, instr;
  logic       inst_valid, done;
  logic [15:0] inst_count;

  logic [8:0] rom [256];

  int checks = 0;
  int failures = 0;

  int m_st, m_pc, m_instr, m_ipc, m_valid, m_count;

  always #5 clk = ~clk;

  assign inst_in = rom[inst_address];

  instr_fetch_ctrl dut (
    .Clk(clk), .Reset(reset), .Start(start),
    .InstAddress(inst_address), .InstIn(inst_in),
    .Instr(instr), .InstPC(inst_pc), .InstValid(inst_valid),
    .InstReady(ready), .BranchEn(br_en), .BranchRel(br_rel),
    .BranchTarget(br_tgt), .Done(done), .InstCount(inst_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: m_st 0=idle, 1=running, 2=halted.
  task automatic model_step();
    int acc;
    if (reset) begin
      m_st = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_count = 0;
    end else if (m_st != 1) begin
      if (start) begin
        m_st = 1; m_pc = 0; m_valid = 0; m_count = 0;
      end
    end else begin
      acc = (m_valid == 1 && ready) ? 1 : 0;
      if (acc == 1 && m_count < 65535) m_count++;
      if (acc == 1 && br_en) begin
        m_pc    = br_rel ? (m_ipc + int'(br_tgt)) % 256 : int'(br_tgt);
        m_valid = 0;
      end else if (m_valid == 0 || acc == 1) begin
        if (rom[m_pc] == 9'h1FF) begin
          m_valid = 0;
          m_st    = 2;
        end else begin
          m_instr = int'(rom[m_pc]);
          m_ipc   = m_pc;
          m_valid = 1;
          m_pc    = (m_pc + 1) % 256;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_eq("pc",    32'(inst_address), 32'(m_pc));
    check_eq("valid", 32'(inst_valid),   32'(m_valid));
    check_eq("instr", 32'(instr),        32'(m_instr));
    check_eq("ipc",   32'(inst_pc),      32'(m_ipc));
    check_eq("done",  32'(done),         (m_st == 2) ? 32'd1 : 32'd0);
    check_eq("count", 32'(inst_count),   32'(m_count));
  endtask

  task automatic idle_inputs();
    reset = 1'b0; start = 1'b0; ready = 1'b1; br_en = 1'b0; br_rel = 1'b0; br_tgt = 8'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_ipc(input string tag, input logic [7:0] target, input int budget);
    for (int i = 0; i < budget && !(inst_valid && inst_pc == target); i++) cycle();
    check_eq(tag, {23'd0, inst_valid, inst_pc}, {23'd0, 1'b1, target});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'd0;
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_count", 32'(inst_count), 32'd0);

    // Three-word program ending in halt.
    rom[0] = 9'h10C; rom[1] = 9'h13C; rom[2] = 9'h1FF;
    reset = 1'b0;
    do_start();
    check_eq("s1_addr0", 32'(inst_address), 32'd0);
    cycle();
    check_eq("s1_i0", 32'(instr), 32'h10C);
    cycle();
    check_eq("s1_i1", 32'(instr), 32'h13C);
    cycle();
    check_eq("s1_done", 32'(done), 32'd1);
    check_eq("s1_cnt", 32'(inst_count), 32'd2);
    check_eq("s1_addr", 32'(inst_address), 32'd2);
    cycle();

    // Stall while 9'h13C is presented.
    rom[2] = 9'h020; rom[3] = 9'h1FF;
    do_start();
    cycle();
    cycle();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("s2_instr", 32'(instr), 32'h13C);
      check_eq("s2_ipc", 32'(inst_pc), 32'd1);
      check_eq("s2_pc", 32'(inst_address), 32'd2);
      check_eq("s2_cnt", 32'(inst_count), 32'd1);
    end
    ready = 1'b1;
    cycle();
    check_eq("s2_resume", 32'(instr), 32'h020);
    cycle();
    check_eq("s2_done", 32'(done), 32'd1);

    // Branches, halt under branch, PC wrap.
    for (int i = 0; i < 256; i++) rom[i] = 9'(i);
    rom[8'h21] = 9'h1FF;
    do_start();
    wait_ipc("s3_at5", 8'd5, 20);
    br_en = 1'b1; br_rel = 1'b1; br_tgt = 8'hFE;
    cycle();
    check_eq("s3_bubble", 32'(inst_valid), 32'd0);
    br_en = 1'b0;
    cycle();
    check_eq("s3_rel", 32'(inst_pc), 32'd3);
    br_en = 1'b1; br_rel = 1'b0; br_tgt = 8'h20;
    cycle();
    br_en = 1'b0;
    cycle();
    check_eq("s3_abs", 32'(inst_pc), 32'h20);
    br_en = 1'b1; br_tgt = 8'h40;
    cycle();
    check_eq("s4_nodone", 32'(done), 32'd0);
    br_en = 1'b0;
    cycle();
    check_eq("s4_tgt", 32'(inst_pc), 32'h40);
    br_en = 1'b1; br_tgt = 8'hFE;
    cycle();
    br_en = 1'b0;
    wait_ipc("s5_ff", 8'hFF, 10);
    cycle();
    check_eq("s5_wrap", 32'(inst_pc), 32'd0);

    // Reset in the middle of a run, then restart.
    reset = 1'b1;
    cycle();
    check_eq("s6_valid", 32'(inst_valid), 32'd0);
    check_eq("s6_instr", 32'(instr), 32'd0);
    check_eq("s6_cnt", 32'(inst_count), 32'd0);
    reset = 1'b0;
    do_start();
    cycle();
    check_eq("s6_ipc", 32'(inst_pc), 32'd0);
    check_eq("s6_cnt2", 32'(inst_count), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 31) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
    for (int n = 0; n < 4000; n++) begin
      reset  = ($urandom_range(0, 299) == 0);
      start  = ($urandom_range(0, 15) == 0);
      ready  = ($urandom_range(0, 9) < 7);
      br_en  = ($urandom_range(0, 3) == 0);
      br_rel = 1'($urandom_range(0, 1));
      br_tgt = 8'($urandom_range(0, 255));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
